seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
- Downstream consumer of the six 6-bit character codes produced by the digit separator.
- Snapshots the codes once per frame and time-multiplexes them onto a six-digit common-segment 7-segment display.
- Provides anti-ghosting blanking and per-digit blinking for time-set mode.
- Sits between the digit separator and the board pins.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot (1 kHz/digit at 50 MHz); must be ≥ 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all digits disabled; must be < SCAN_DIV; 0 disables.
- BLINK_DIV, 25000000: cycles per blink half-period.
- SEG_ACTIVE_LOW, 1: 1 = segment outputs inverted (segment on = 0).
- DIG_ACTIVE_LOW, 1: 1 = digit enables inverted (digit on = 0).

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_digit_pos  in  6  char code, digit 0 (rightmost)
- i_ten_pos  in  6  char code, digit 1
- i_hundred_pos  in  6  char code, digit 2
- i_thousand_pos  in  6  char code, digit 3
- i_ten_thousand_pos  in  6  char code, digit 4
- i_hundred_thousand_pos  in  6  char code, digit 5 (leftmost)
- i_blink_mask  in  6  bit n = 1 blinks digit n
- o_seg  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- o_dig_en  out  6  digit enables, bit n = digit n, polarity per DIG_ACTIVE_LOW
- o_frame_tick  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset: one clock domain (i_clk); reset is asynchronous and active-low on i_rst_n.
- Reset values:
  - prescaler = 0, slot index = 0, blink phase = 0, load_pending = 1.
  - All six shadow regs = 6'h25 (blank).
  - o_seg = all segments off, o_dig_en = all digits off, o_frame_tick = 0.
- Character codes:
  - 0x00–0x09: digits 0–9.
  - 0x0A–0x23: letters A–Z (A = 0x0A, E = 0x0E, O = 0x18, R = 0x1B).
  - 0x24: minus (segment g only).
  - 0x25: blank.
  - Letters with no 7-seg form (K, M, V, W, X) and all codes ≥ 0x26 render blank.
- Active-high patterns: 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F, A = 77, E = 79, O = 3F, R = 50, minus = 40, blank = 00.
- Prescaler counts 0..SCAN_DIV-1 and wraps. On wrap, the slot index advances 0→1→…→5→0.
- Snapshot: all six inputs are copied into the shadow regs in the same cycle, so there is no tearing. This happens when:
  - load_pending = 1 (first cycle after reset release; load_pending then clears), or
  - the prescaler wraps while index = 5.
- o_frame_tick is registered and asserts high for exactly the cycle after each snapshot.
- Inputs are ignored except at a snapshot; mid-frame changes appear only in the next frame.
- Blink: a free-running counter toggles the blink phase every BLINK_DIV cycles. The digit being shown is rendered blank when blink phase = 1 and its mask bit = 1. i_blink_mask is sampled live, not snapshotted.
- Output timing: o_seg and o_dig_en are registered, so they show the state of the previous cycle (1-cycle latency).
- Ghost blanking: while prescaler < BLANK_CYCLES, o_dig_en = all off and o_seg = all off.
- After the blanking window, exactly one o_dig_en bit is active (bit = index) and o_seg holds the decoded shadow code for that index.
- Reset mid-frame: outputs return immediately (asynchronously) to their reset values. After release, a new snapshot is taken and the scan restarts from digit 0.
- Implementation asserts BLANK_CYCLES < SCAN_DIV in simulation.

Decomposition:
- Shared package/include seg_defs holds:
  - character code constants: CH_MINUS = 6'h24, CH_BLANK = 6'h25, CH_A … CH_Z;
  - the code-to-pattern table;
  - digit count constant NUM_DIGITS = 6.
- One combinational sub-module, char_to_seg: 6-bit code in → 7-bit active-high pattern out. It is instantiated once, after the shadow mux. Polarity inversion and blink blanking are applied in the scanner.

Test Plan:
Bench parameters: SCAN_DIV = 8, BLANK_CYCLES = 2, BLINK_DIV = 64, both active-low.
1. Reset, inputs 1,2,3,4,5,6 (digit0..5), mask 0 → o_frame_tick pulses once after release; each slot shows o_dig_en = 6'h3F for 2 cycles, then 6'h3E with o_seg = ~06 for 6 cycles, then 6'h3D with ~5B … up to 6'h1F with ~7D; cycle repeats every 48 clocks.
2. Inputs 1B,18,1B,1B,0E,25 (error word) → digits show R,O,R,R,E,blank (patterns ~50,~3F,~50,~50,~79,7F); code 0x24 on digit5 → ~40; code 0x3F → all off.
3. Change i_digit_pos from 1 to 9 while index = 3 → digit0 still shows 1 until the next o_frame_tick; the following frame shows ~6F.
4. Mask 6'b000001, inputs all 8 → digit0 shows ~7F for 64 cycles, then 7F (off) for 64 cycles; other digits are unaffected.
5. Assert i_rst_n low mid-slot at index 4 → same cycle o_seg = 7F, o_dig_en = 3F; after release a snapshot is taken and index 0 is shown first.
6. BLANK_CYCLES = 0 build → no all-off gap; exactly one digit enable is active in every cycle after the first frame starts.

Source files
------------

// File: rtl/seg_defs.sv
// Shared character-code constants and the code-to-segment table for the
// six-digit 7-segment scanner.
package seg_defs;

    localparam int NUM_DIGITS = 6;

    localparam logic [5:0] CH_A = 6'h0A, CH_B = 6'h0B, CH_C = 6'h0C, CH_D = 6'h0D;
    localparam logic [5:0] CH_E = 6'h0E, CH_F = 6'h0F, CH_G = 6'h10, CH_H = 6'h11;
    localparam logic [5:0] CH_I = 6'h12, CH_J = 6'h13, CH_K = 6'h14, CH_L = 6'h15;
    localparam logic [5:0] CH_M = 6'h16, CH_N = 6'h17, CH_O = 6'h18, CH_P = 6'h19;
    localparam logic [5:0] CH_Q = 6'h1A, CH_R = 6'h1B, CH_S = 6'h1C, CH_T = 6'h1D;
    localparam logic [5:0] CH_U = 6'h1E, CH_V = 6'h1F, CH_W = 6'h20, CH_X = 6'h21;
    localparam logic [5:0] CH_Y = 6'h22, CH_Z = 6'h23;
    localparam logic [5:0] CH_MINUS = 6'h24;
    localparam logic [5:0] CH_BLANK = 6'h25;

    // Active-high pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] char_pattern(input logic [5:0] code);
        logic [6:0] pat;
        case (code)
            6'h00: pat = 7'h3F;
            6'h01: pat = 7'h06;
            6'h02: pat = 7'h5B;
            6'h03: pat = 7'h4F;
            6'h04: pat = 7'h66;
            6'h05: pat = 7'h6D;
            6'h06: pat = 7'h7D;
            6'h07: pat = 7'h07;
            6'h08: pat = 7'h7F;
            6'h09: pat = 7'h6F;
            CH_A:  pat = 7'h77;
            CH_B:  pat = 7'h7C;
            CH_C:  pat = 7'h39;
            CH_D:  pat = 7'h5E;
            CH_E:  pat = 7'h79;
            CH_F:  pat = 7'h71;
            CH_G:  pat = 7'h3D;
            CH_H:  pat = 7'h76;
            CH_I:  pat = 7'h30;
            CH_J:  pat = 7'h1E;
            CH_L:  pat = 7'h38;
            CH_N:  pat = 7'h54;
            CH_O:  pat = 7'h3F;
            CH_P:  pat = 7'h73;
            CH_Q:  pat = 7'h67;
            CH_R:  pat = 7'h50;
            CH_S:  pat = 7'h6D;
            CH_T:  pat = 7'h78;
            CH_U:  pat = 7'h3E;
            CH_Y:  pat = 7'h6E;
            CH_Z:  pat = 7'h5B;
            CH_MINUS: pat = 7'h40;
            // Letters that have no readable 7-segment form stay dark.
            CH_K, CH_M, CH_V, CH_W, CH_X, CH_BLANK: pat = 7'h00;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/char_to_seg.sv
// Combinational character-code to active-high segment pattern decoder.
module char_to_seg
    import seg_defs::*;
(
    input  logic [5:0] i_code,
    output logic [6:0] o_pattern
);

    assign o_pattern = char_pattern(i_code);

endmodule

// File: rtl/seven_seg_scanner.sv
// Six-digit multiplexed 7-segment scanner: per-frame snapshot of the character
// codes, per-slot ghost blanking, per-digit blinking and registered pin outputs.
module seven_seg_scanner
    import seg_defs::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 16,
    parameter int BLINK_DIV      = 25000000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_digit_pos,
    input  logic [5:0] i_ten_pos,
    input  logic [5:0] i_hundred_pos,
    input  logic [5:0] i_thousand_pos,
    input  logic [5:0] i_ten_thousand_pos,
    input  logic [5:0] i_hundred_thousand_pos,
    input  logic [5:0] i_blink_mask,
    output logic [6:0] o_seg,
    output logic [5:0] o_dig_en,
    output logic       o_frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);
    // XOR masks that turn active-high values into pin polarity; also the "off" value.
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [5:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          load_pending_q, load_pending_d;
    logic [5:0]    shadow_q [NUM_DIGITS];
    logic [5:0]    shadow_d [NUM_DIGITS];
    logic [6:0]    seg_q, seg_d;
    logic [5:0]    dig_en_q, dig_en_d;
    logic          frame_tick_q, frame_tick_d;

    logic [5:0]    in_codes [NUM_DIGITS];
    logic [5:0]    cur_code;
    logic [6:0]    cur_pattern;
    logic          in_blank;
    logic          presc_wrap;
    logic          snapshot;
    logic [6:0]    seg_hi;
    logic [5:0]    dig_hi;

    assign in_codes[0] = i_digit_pos;
    assign in_codes[1] = i_ten_pos;
    assign in_codes[2] = i_hundred_pos;
    assign in_codes[3] = i_thousand_pos;
    assign in_codes[4] = i_ten_thousand_pos;
    assign in_codes[5] = i_hundred_thousand_pos;

    if (BLANK_CYCLES > 0) begin : g_blank
        assign in_blank = (presc_q < PW'(BLANK_CYCLES));
    end else begin : g_no_blank
        assign in_blank = 1'b0;
    end

    assign cur_code = shadow_q[idx_q];

    char_to_seg u_char_to_seg (
        .i_code    (cur_code),
        .o_pattern (cur_pattern)
    );

    always_comb begin
        presc_wrap     = (presc_q == PRESC_LAST);
        presc_d        = presc_wrap ? '0 : presc_q + 1'b1;
        idx_d          = idx_q;
        if (presc_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end

        // All six codes are captured together so a frame never mixes old and new values.
        snapshot       = load_pending_q || (presc_wrap && (idx_q == IDX_LAST));
        load_pending_d = 1'b0;
        frame_tick_d   = snapshot;
        shadow_d       = shadow_q;
        if (snapshot) begin
            shadow_d = in_codes;
        end

        blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
        blink_d     = blink_q ^ (blink_cnt_q == BLINK_LAST);

        seg_hi = '0;
        dig_hi = '0;
        if (!in_blank) begin
            dig_hi = 6'd1 << idx_q;
            if (!(blink_q && i_blink_mask[idx_q])) begin
                seg_hi = cur_pattern;
            end
        end
        seg_d    = seg_hi ^ SEG_OFF;
        dig_en_d = dig_hi ^ DIG_OFF;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q        <= '0;
            idx_q          <= '0;
            blink_cnt_q    <= '0;
            blink_q        <= 1'b0;
            load_pending_q <= 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow_q[i] <= CH_BLANK;
            end
            seg_q          <= SEG_OFF;
            dig_en_q       <= DIG_OFF;
            frame_tick_q   <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_q        <= blink_d;
            load_pending_q <= load_pending_d;
            shadow_q       <= shadow_d;
            seg_q          <= seg_d;
            dig_en_q       <= dig_en_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign o_seg        = seg_q;
    assign o_dig_en     = dig_en_q;
    assign o_frame_tick = frame_tick_q;

    a_blank_range: assert property (@(posedge i_clk) (BLANK_CYCLES < SCAN_DIV))
        else $error("BLANK_CYCLES must be smaller than SCAN_DIV");

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: two builds (with and without ghost blanking)
// compared every cycle against a time-based model of the display schedule.
module tb_seven_seg_scanner;

    localparam int SCAN  = 8;
    localparam int BLANK = 2;
    localparam int BLINK = 64;
    localparam int FRAME = SCAN * 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] codes [6];
    logic [5:0] mask;
    logic [6:0] seg_a, seg_b;
    logic [5:0] dig_a, dig_b;
    logic       tick_a, tick_b;

    int n_cmp = 0;
    int n_bad = 0;
    int k;
    logic [5:0] m_shadow [6];

    logic [6:0] digit_pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [5:0] pool [23] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                              6'h07, 6'h08, 6'h09, 6'h0A, 6'h0E, 6'h18, 6'h1B,
                              6'h24, 6'h25, 6'h14, 6'h16, 6'h1F, 6'h20, 6'h21,
                              6'h26, 6'h3F};

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .SCAN_DIV(SCAN), .BLANK_CYCLES(BLANK), .BLINK_DIV(BLINK),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_digit_pos(codes[0]), .i_ten_pos(codes[1]), .i_hundred_pos(codes[2]),
        .i_thousand_pos(codes[3]), .i_ten_thousand_pos(codes[4]),
        .i_hundred_thousand_pos(codes[5]), .i_blink_mask(mask),
        .o_seg(seg_a), .o_dig_en(dig_a), .o_frame_tick(tick_a)
    );

    seven_seg_scanner #(
        .SCAN_DIV(SCAN), .BLANK_CYCLES(0), .BLINK_DIV(BLINK),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_digit_pos(codes[0]), .i_ten_pos(codes[1]), .i_hundred_pos(codes[2]),
        .i_thousand_pos(codes[3]), .i_ten_thousand_pos(codes[4]),
        .i_hundred_thousand_pos(codes[5]), .i_blink_mask(mask),
        .o_seg(seg_b), .o_dig_en(dig_b), .o_frame_tick(tick_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t cyc=%0d: got %0h expected %0h", tag, $time, k, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_pat(input logic [5:0] c);
        if (c <= 6'h09) return digit_pat[c];
        case (c)
            6'h0A: return 7'h77;
            6'h0E: return 7'h79;
            6'h18: return 7'h3F;
            6'h1B: return 7'h50;
            6'h24: return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    // Output after clock edge k, derived from elapsed time since reset release.
    function automatic void model(input int blank, output logic [6:0] s, output logic [5:0] d);
        int p, idx, ph;
        logic [6:0] pat;
        p   = (k - 1) % SCAN;
        idx = ((k - 1) / SCAN) % 6;
        ph  = ((k - 1) / BLINK) % 2;
        if (p < blank) begin
            s = 7'h7F;
            d = 6'h3F;
        end else begin
            pat = (ph == 1 && mask[idx]) ? 7'h00 : ref_pat(m_shadow[idx]);
            s = ~pat;
            d = ~(6'd1 << idx);
        end
    endfunction

    task automatic step();
        logic [6:0] es_a, es_b;
        logic [5:0] ed_a, ed_b;
        logic       et;
        @(posedge clk);
        k++;
        et = (k == 1) || (k % FRAME == 0);
        model(BLANK, es_a, ed_a);
        model(0, es_b, ed_b);
        if (et) begin
            for (int i = 0; i < 6; i++) m_shadow[i] = codes[i];
        end
        #1;
        check_eq("seg_a", seg_a, es_a);
        check_eq("dig_a", dig_a, ed_a);
        check_eq("tick_a", tick_a, et);
        check_eq("seg_b", seg_b, es_b);
        check_eq("dig_b", dig_b, ed_b);
        check_eq("tick_b", tick_b, et);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check_eq("rst_seg_a", seg_a, 7'h7F);
        check_eq("rst_dig_a", dig_a, 6'h3F);
        check_eq("rst_tick_a", tick_a, 1'b0);
        check_eq("rst_seg_b", seg_b, 7'h7F);
        check_eq("rst_dig_b", dig_b, 6'h3F);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 6; i++) m_shadow[i] = 6'h25;
    endtask

    task automatic run_until(input int idx, input int p);
        int guard = 0;
        while (!((((k - 1) / SCAN) % 6 == idx) && ((k - 1) % SCAN == p)) && guard < 200) begin
            step();
            guard++;
        end
        check_eq("run_until_bound", (guard < 200), 1'b1);
    endtask

    initial begin
        k = 0;
        mask = 6'h00;
        for (int i = 0; i < 6; i++) codes[i] = 6'(i + 1);
        apply_reset();
        run(2 * FRAME);

        // Error word R,O,R,R,E,blank
        codes[0] = 6'h1B; codes[1] = 6'h18; codes[2] = 6'h1B;
        codes[3] = 6'h1B; codes[4] = 6'h0E; codes[5] = 6'h25;
        run(2 * FRAME);
        codes[5] = 6'h24;
        run(FRAME);
        codes[5] = 6'h3F;
        codes[2] = 6'h3F;
        run(FRAME);

        // Mid-frame change only shows from the next snapshot on
        for (int i = 0; i < 6; i++) codes[i] = 6'h01;
        run(FRAME);
        run_until(3, 4);
        codes[0] = 6'h09;
        run(2 * FRAME);

        // Blinking digit 0
        for (int i = 0; i < 6; i++) codes[i] = 6'h08;
        mask = 6'b000001;
        run(4 * BLINK);
        mask = 6'b100100;
        run(2 * BLINK);
        mask = 6'h00;

        // Asynchronous reset in the middle of slot 4
        run_until(4, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_seg_a", seg_a, 7'h7F);
        check_eq("async_dig_a", dig_a, 6'h3F);
        check_eq("async_tick_a", tick_a, 1'b0);
        check_eq("async_seg_b", seg_b, 7'h7F);
        check_eq("async_dig_b", dig_b, 6'h3F);
        for (int i = 0; i < 6; i++) codes[i] = 6'(5 - i);
        apply_reset();
        run(2 * FRAME);

        // Random codes and masks, changed at random points in the frame
        for (int c = 0; c < 900; c++) begin
            if ($urandom_range(0, 7) == 0)
                codes[$urandom_range(0, 5)] = pool[$urandom_range(0, 22)];
            if ($urandom_range(0, 15) == 0)
                mask = 6'($urandom_range(0, 63));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
